// File: rtl/mc_decode_queue.sv
// mc_decode_queue: instruction buffer in front of an RV32I/RV32A decoder.
// Fetched words are pushed into a circular FIFO. The head is decoded and
// loaded into a registered output bundle that is held under backpressure.
// A halt instruction freezes the queue once it is consumed.
//
// Ports
//   CLK, nRST           clock, asynchronous active-low reset
//   in_valid/in_instr   fetch push request and instruction word
//   in_ready            queue accepts in_instr this cycle
//   flush               discard all buffered and decoded instructions
//   out_valid/out_ready decoded bundle handshake
//   rs1..rdSel          registered decoded bundle
//   count               occupied FIFO entries (output register excluded)
//   halted              sticky, set when a halt has been consumed
module mc_decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          in_valid,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    rs1,
  output logic [4:0]    rs2,
  output logic [4:0]    rd,
  output logic [3:0]    aluOp,
  output logic          regWr,
  output logic          dREN,
  output logic          dWEN,
  output logic          aluSrc,
  output logic          jpSel,
  output logic          atomic,
  output logic          halt,
  output logic          illegal,
  output logic [11:0]   imm,
  output logic [1:0]    pcSrc,
  output logic [2:0]    rdSel,
  output logic [CW-1:0] count,
  output logic          halted
);

  localparam int unsigned PW = $clog2(DEPTH);

  // ALU operation encoding
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_AMO    = 7'b0101111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  localparam logic [4:0] F5_LR = 5'b00010;
  localparam logic [4:0] F5_SC = 5'b00011;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_wr;
    logic        d_ren;
    logic        d_wen;
    logic        alu_src;
    logic        jp_sel;
    logic        atomic;
    logic        halt;
    logic        illegal;
    logic [11:0] imm;
    logic [1:0]  pc_src;
    logic [2:0]  rd_sel;
  } bundle_t;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  bundle_t       bundle_q;
  bundle_t       dec;
  logic [31:0]   head;
  logic          push;
  logic          pop;
  logic          consume;
  logic          halt_pending;

  // ALU op for R-type and I-type ALU; alt selects SUB/SRA, SUB only when allowed
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt,
                                         input logic allow_sub);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Handshakes; a halt sitting in or past the output stage blocks pops
  assign halt_pending = out_valid && bundle_q.halt;
  assign consume      = out_valid && out_ready;
  assign in_ready     = (count < CW'(DEPTH)) && !halted && !halt_pending;
  assign push         = in_valid && in_ready;
  assign pop          = (count != '0) && (!out_valid || consume) && !halt_pending && !halted;

  assign head = mem[rd_ptr];

  // Decode of the FIFO head
  always_comb begin
    dec     = '0;
    dec.rs1 = head[19:15];
    dec.rs2 = head[24:20];
    dec.rd  = head[11:7];
    case (head[6:0])
      OP_R: begin
        dec.reg_wr = 1'b1;
        dec.alu_op = alu_sel(head[14:12], head[30], 1'b1);
      end
      OP_I: begin
        dec.reg_wr  = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm     = head[31:20];
        dec.alu_op  = alu_sel(head[14:12], head[30], 1'b0);
      end
      OP_LOAD: begin
        dec.reg_wr  = 1'b1;
        dec.d_ren   = 1'b1;
        dec.alu_src = 1'b1;
        dec.rd_sel  = 3'd1;
        dec.imm     = head[31:20];
        dec.alu_op  = ALU_ADD;
      end
      OP_STORE: begin
        dec.d_wen   = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm     = {head[31:25], head[11:7]};
        dec.alu_op  = ALU_ADD;
      end
      OP_BRANCH: begin
        dec.pc_src = 2'd1;
        case (head[14:12])
          3'b000, 3'b001: dec.alu_op = ALU_SUB;
          3'b100, 3'b101: dec.alu_op = ALU_SLT;
          3'b110, 3'b111: dec.alu_op = ALU_SLTU;
          default: begin
            dec.pc_src  = 2'd0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_JAL: begin
        dec.reg_wr = 1'b1;
        dec.pc_src = 2'd2;
        dec.rd_sel = 3'd2;
      end
      OP_JALR: begin
        dec.reg_wr  = 1'b1;
        dec.pc_src  = 2'd2;
        dec.jp_sel  = 1'b1;
        dec.alu_src = 1'b1;
        dec.rd_sel  = 3'd2;
        dec.imm     = head[31:20];
      end
      OP_LUI: begin
        dec.reg_wr = 1'b1;
        dec.rd_sel = 3'd3;
      end
      OP_AUIPC: begin
        dec.reg_wr = 1'b1;
        dec.rd_sel = 3'd4;
      end
      OP_AMO: begin
        if (head[31:27] == F5_LR) begin
          dec.reg_wr = 1'b1;
          dec.d_ren  = 1'b1;
          dec.atomic = 1'b1;
          dec.rd_sel = 3'd1;
        end else if (head[31:27] == F5_SC) begin
          dec.reg_wr = 1'b1;
          dec.d_wen  = 1'b1;
          dec.atomic = 1'b1;
          dec.rd_sel = 3'd5;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_HALT: dec.halt = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

  // FIFO storage; contents are only visible through the pointers, so no reset
  always_ff @(posedge CLK) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_instr;
    end
  end

  // Pointers, occupancy, output stage and halt flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      bundle_q  <= '0;
      halted    <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (pop) begin
        out_valid <= 1'b1;
        bundle_q  <= dec;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
      if (consume && bundle_q.halt) begin
        halted <= 1'b1;
      end
    end
  end

  assign rs1     = bundle_q.rs1;
  assign rs2     = bundle_q.rs2;
  assign rd      = bundle_q.rd;
  assign aluOp   = bundle_q.alu_op;
  assign regWr   = bundle_q.reg_wr;
  assign dREN    = bundle_q.d_ren;
  assign dWEN    = bundle_q.d_wen;
  assign aluSrc  = bundle_q.alu_src;
  assign jpSel   = bundle_q.jp_sel;
  assign atomic  = bundle_q.atomic;
  assign halt    = bundle_q.halt;
  assign illegal = bundle_q.illegal;
  assign imm     = bundle_q.imm;
  assign pcSrc   = bundle_q.pc_src;
  assign rdSel   = bundle_q.rd_sel;

endmodule
